oclib_bc_tree_router: RTL

OCLIB_BC_TREE_ROUTER -- requirements
Module: oclib_bc_tree_router

---
 rtl/oclib_pkg.sv | 20 ++
 rtl/oclib_bc_id_match.sv | 34 +++
 rtl/oclib_bc_tree_router.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oclib_pkg.sv
// Shared types and constants for the byte-channel (bc) library.
package oclib_pkg;

    // One byte-wide channel: data/valid travel with the flow, ready flows back.
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;

    // Default block id width on the bc tree.
    localparam int BlockIdBits = 16;

    // Length bytes at or above this value are never legal and are used to resync.
    localparam logic [7:0] BcResyncThreshold = 8'h78;

    // Status byte returned when the router answers on behalf of a child.
    localparam logic [7:0] BcErrorCode = 8'hEE;

endpackage

// File: rtl/oclib_bc_id_match.sv
// Priority block-id decoder: lowest-index output whose key rule matches wins.
module oclib_bc_id_match #(
    parameter int                     Outputs     = 4,
    parameter int                     BlockIdBits = 16,
    parameter logic [BlockIdBits-1:0] OutputBlockIdKey  [0:Outputs-1] = '{default: '1},
    parameter logic [BlockIdBits-1:0] OutputBlockIdMask [0:Outputs-1] = '{default: '0}
) (
    input  logic [BlockIdBits-1:0] id,
    output logic [Outputs-1:0]     onehot,
    output logic                   hit
);

    logic m;

    // Scan outputs in ascending order and keep only the first match.
    always_comb begin
        onehot = '0;
        hit    = 1'b0;
        m      = 1'b0;
        for (int i = 0; i < Outputs; i++) begin
            // An all-ones key means "this output answers to its own index".
            if (OutputBlockIdKey[i] == '1) begin
                m = (id == BlockIdBits'(i));
            end else begin
                m = ((id & ~OutputBlockIdMask[i]) == OutputBlockIdKey[i]);
            end
            if (!hit && m) begin
                onehot[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oclib_bc_tree_router.sv
// Byte-channel tree router: routes a request to one child by block id and
// returns that child's response, or a local error response on no-match/timeout.
module oclib_bc_tree_router #(
    parameter type                    BcType        = oclib_pkg::bc_8b_bidi_s,
    parameter int                     Outputs       = 4,
    parameter int                     BlockIdBits   = oclib_pkg::BlockIdBits,
    parameter logic [BlockIdBits-1:0] OutputBlockIdKey  [0:Outputs-1] = '{default: '1},
    parameter logic [BlockIdBits-1:0] OutputBlockIdMask [0:Outputs-1] = '{default: '0},
    parameter int                     TimeoutCycles = 1024,
    parameter logic [7:0]             ErrorCode     = oclib_pkg::BcErrorCode
) (
    input  logic  clock,
    input  logic  reset,
    input  BcType upIn,
    output BcType upOut,
    output BcType downOut [0:Outputs-1],
    input  BcType downIn  [0:Outputs-1],
    output logic  noMatchPulse,
    output logic  timeoutPulse
);

    import oclib_pkg::*;

    localparam int         BlockBytes = BlockIdBits / 8;
    localparam logic [7:0] BbByte     = 8'(BlockBytes);
    localparam int         SelW       = (Outputs > 1) ? $clog2(Outputs) : 1;
    localparam int         TmoW       = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_BLOCK    = 4'd1;
    localparam logic [3:0] S_MATCH    = 4'd2;
    localparam logic [3:0] S_FWDHDR   = 4'd3;
    localparam logic [3:0] S_FWDPAY   = 4'd4;
    localparam logic [3:0] S_DRAIN    = 4'd5;
    localparam logic [3:0] S_RESPLEN  = 4'd6;
    localparam logic [3:0] S_RESPCOPY = 4'd7;
    localparam logic [3:0] S_ERRLEN   = 4'd8;
    localparam logic [3:0] S_ERRCODE  = 4'd9;

    logic [3:0]             state_q, state_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [BlockIdBits-1:0] id_q, id_d;
    logic [SelW-1:0]        sel_q, sel_d;
    logic                   dvalid_q, dvalid_d;
    logic [7:0]             ddata_q, ddata_d;
    logic                   uvalid_q, uvalid_d;
    logic [7:0]             udata_q, udata_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;

    logic [Outputs-1:0] match_onehot;
    logic               match_hit;
    logic [SelW-1:0]    match_idx;
    logic               sel_dn_valid, sel_dn_ready;
    logic [7:0]         sel_dn_data;
    logic               up_rdy, resp_rdy, resp_state, dn_space, up_space, tmo_hit;
    logic               dn_load, up_load;
    logic [7:0]         dn_data, up_data;

    oclib_bc_id_match #(
        .Outputs          (Outputs),
        .BlockIdBits      (BlockIdBits),
        .OutputBlockIdKey (OutputBlockIdKey),
        .OutputBlockIdMask(OutputBlockIdMask)
    ) u_match (
        .id    (id_q),
        .onehot(match_onehot),
        .hit   (match_hit)
    );

    // Encode the match vector and pick out the selected child's channel.
    always_comb begin
        match_idx    = '0;
        sel_dn_valid = 1'b0;
        sel_dn_ready = 1'b0;
        sel_dn_data  = '0;
        for (int i = 0; i < Outputs; i++) begin
            if (match_onehot[i]) match_idx = SelW'(i);
            if (sel_q == SelW'(i)) begin
                sel_dn_valid = downIn[i].valid;
                sel_dn_ready = downIn[i].ready;
                sel_dn_data  = downIn[i].data;
            end
        end
    end

    assign dn_space   = !dvalid_q || sel_dn_ready;
    assign up_space   = !uvalid_q || upIn.ready;
    assign resp_state = (state_q == S_RESPLEN) || (state_q == S_RESPCOPY);
    assign tmo_hit    = (TimeoutCycles != 0) && (tmo_q == TmoW'(TimeoutCycles));
    assign resp_rdy   = resp_state && up_space && !tmo_hit;

    // Next-state, counters and the two single-entry output registers.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        dvalid_d = dvalid_q;
        ddata_d  = ddata_q;
        uvalid_d = uvalid_q;
        udata_d  = udata_q;
        up_rdy   = 1'b0;
        dn_load  = 1'b0;
        dn_data  = '0;
        up_load  = 1'b0;
        up_data  = '0;
        case (state_q)
            S_IDLE: begin
                up_rdy = 1'b1;
                // Illegal lengths are swallowed so a stream of them resyncs the tree.
                if (upIn.valid && !(upIn.data >= BcResyncThreshold || upIn.data < BbByte)) begin
                    len_d   = upIn.data;
                    cnt_d   = '0;
                    id_d    = '0;
                    state_d = S_BLOCK;
                end
            end
            S_BLOCK: begin
                up_rdy = 1'b1;
                if (upIn.valid) begin
                    id_d  = (id_q << 8) | BlockIdBits'(upIn.data);
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == BbByte - 8'd1) begin
                        cnt_d   = '0;
                        state_d = S_MATCH;
                    end
                end
            end
            S_MATCH: begin
                if (match_hit) begin
                    sel_d   = match_idx;
                    cnt_d   = '0;
                    state_d = S_FWDHDR;
                end else if (len_q == BbByte) begin
                    state_d = S_ERRLEN;
                end else begin
                    cnt_d   = BbByte;
                    state_d = S_DRAIN;
                end
            end
            S_FWDHDR: begin
                // Replay L, then the id bytes MSB first by rotating the id register.
                if (dn_space) begin
                    dn_load = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == 8'd0) begin
                        dn_data = len_q;
                    end else begin
                        dn_data = id_q[BlockIdBits-1 -: 8];
                        id_d    = (id_q << 8) | (id_q >> (BlockIdBits - 8));
                    end
                    if (cnt_q == BbByte) begin
                        cnt_d   = BbByte;
                        state_d = S_FWDPAY;
                    end
                end
            end
            S_FWDPAY: begin
                if (cnt_q != len_q) begin
                    up_rdy = dn_space;
                    if (upIn.valid && dn_space) begin
                        dn_load = 1'b1;
                        dn_data = upIn.data;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end else if (dn_space) begin
                    tmo_d   = '0;
                    state_d = S_RESPLEN;
                end
            end
            S_DRAIN: begin
                up_rdy = 1'b1;
                if (upIn.valid) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == len_q) state_d = S_ERRLEN;
                end
            end
            S_RESPLEN, S_RESPCOPY: begin
                if (tmo_hit) begin
                    tmo_d   = '0;
                    state_d = S_ERRLEN;
                end else if (resp_rdy && sel_dn_valid) begin
                    up_load = 1'b1;
                    up_data = sel_dn_data;
                    tmo_d   = '0;
                    if (state_q == S_RESPLEN) begin
                        len_d   = sel_dn_data;
                        cnt_d   = '0;
                        state_d = (sel_dn_data == 8'd0) ? S_IDLE : S_RESPCOPY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == len_q) state_d = S_IDLE;
                    end
                end else if (resp_rdy) begin
                    // Only count cycles where the child could have sent and did not.
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            S_ERRLEN: begin
                if (up_space) begin
                    up_load = 1'b1;
                    up_data = 8'h01;
                    state_d = S_ERRCODE;
                end
            end
            S_ERRCODE: begin
                if (up_space) begin
                    up_load = 1'b1;
                    up_data = ErrorCode;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (dn_load) begin
            dvalid_d = 1'b1;
            ddata_d  = dn_data;
        end else if (sel_dn_ready) begin
            dvalid_d = 1'b0;
        end
        if (up_load) begin
            uvalid_d = 1'b1;
            udata_d  = up_data;
        end else if (upIn.ready) begin
            uvalid_d = 1'b0;
        end
    end

    // State registers; reset abandons any message in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            sel_q    <= '0;
            tmo_q    <= '0;
            dvalid_q <= 1'b0;
            ddata_q  <= '0;
            uvalid_q <= 1'b0;
            udata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            sel_q    <= sel_d;
            tmo_q    <= tmo_d;
            dvalid_q <= dvalid_d;
            ddata_q  <= ddata_d;
            uvalid_q <= uvalid_d;
            udata_q  <= udata_d;
        end
    end

    // Drive channel outputs; readies are gated by reset so they drop at once.
    always_comb begin
        upOut       = '0;
        upOut.data  = udata_q;
        upOut.valid = uvalid_q;
        upOut.ready = up_rdy && reset;
        for (int i = 0; i < Outputs; i++) begin
            downOut[i]       = '0;
            downOut[i].data  = ddata_q;
            downOut[i].valid = dvalid_q && (sel_q == SelW'(i));
            downOut[i].ready = resp_rdy && (sel_q == SelW'(i)) && reset;
        end
    end

    assign noMatchPulse = (state_q == S_MATCH) && !match_hit;
    assign timeoutPulse = resp_state && tmo_hit;

endmodule
